// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: per-cycle dispatch width grant, ROB occupancy tracking and flush recovery.
module dispatch_ctrl #(
    parameter int WAYS        = 3,
    parameter int ROB_SIZE    = 32,
    parameter int FLUSH_STALL = 2,
    parameter int CW          = $clog2(WAYS + 1),
    parameter int OW          = $clog2(ROB_SIZE + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [WAYS-1:0] fetch_valid,
    input  logic [CW-1:0]   rs_avail,
    input  logic [CW-1:0]   freelist_avail,
    input  logic [CW-1:0]   rob_retire_cnt,
    input  logic            branch_flush_en,
    output logic [WAYS-1:0] dispatch_grant,
    output logic [CW-1:0]   dispatch_cnt,
    output logic            fetch_stall,
    output logic            recovering,
    output logic [OW-1:0]   rob_count,
    output logic            rob_full,
    output logic            rob_empty,
    output logic [31:0]     stall_cycles
);
    localparam int SW     = FLUSH_STALL > 1 ? $clog2(FLUSH_STALL) : 1;
    localparam int RELOAD = FLUSH_STALL > 0 ? FLUSH_STALL - 1 : 0;

    typedef enum logic {RUN, RECOVER} state_t;

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_cnt, w_cnt_nxt;
    logic [OW-1:0] r_rob_count;
    logic [31:0]   r_stall_cycles;

    logic          w_run;
    logic [CW-1:0] w_v, w_m1, w_m2, w_nraw, w_n;
    logic [OW-1:0] w_space, w_sum, w_rob_nxt;
    logic          w_under;

    always_comb begin
        w_run = 1'b1;
        w_v   = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_run = w_run & fetch_valid[i];
            w_v   = w_v + CW'(w_run);
        end
        w_space = OW'(ROB_SIZE) - r_rob_count;
        w_m1    = rs_avail < w_v ? rs_avail : w_v;
        w_m2    = freelist_avail < w_m1 ? freelist_avail : w_m1;
        w_nraw  = w_space < OW'(w_m2) ? CW'(w_space) : w_m2;
        w_n     = (reset || r_state == RECOVER || branch_flush_en) ? '0 : w_nraw;
        // Retires only free space for the next cycle; this cycle's grant uses the registered count.
        w_sum     = r_rob_count + OW'(w_n);
        w_under   = OW'(rob_retire_cnt) > w_sum;
        w_rob_nxt = (branch_flush_en || w_under) ? '0 : w_sum - OW'(rob_retire_cnt);
        dispatch_grant = '0;
        for (int i = 0; i < WAYS; i++)
            dispatch_grant[i] = i < int'(w_n);
    end

    assign dispatch_cnt = w_n;
    assign fetch_stall  = w_v > w_n;
    assign rob_count    = r_rob_count;
    assign rob_full     = r_rob_count == OW'(ROB_SIZE);
    assign rob_empty    = r_rob_count == '0;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == RUN) begin
            if (branch_flush_en && FLUSH_STALL > 0) begin
                w_state_nxt = RECOVER;
                w_cnt_nxt   = SW'(RELOAD);
            end
        end else if (branch_flush_en) begin
            w_cnt_nxt = SW'(RELOAD);
        end else if (r_cnt == '0) begin
            w_state_nxt = RUN;
        end else begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    always_comb begin
        recovering = r_state == RECOVER;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rob_count    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (!branch_flush_en)
                assert (!w_under) else $error("dispatch_ctrl: retire count exceeds ROB occupancy");
            r_rob_count    <= w_rob_nxt;
            r_stall_cycles <= r_stall_cycles + 32'(fetch_stall);
        end
    end
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed plus random stimulus, reference model feeds a scoreboard queue.
module tb_dispatch_ctrl;
    localparam int WAYS = 3;
    localparam int ROB  = 32;
    localparam int FS   = 2;
    localparam int CW   = 2;
    localparam int OW   = 6;

    logic            clock = 0;
    logic            reset = 1;
    logic [WAYS-1:0] fetch_valid = '0;
    logic [CW-1:0]   rs_avail = '0, freelist_avail = '0, rob_retire_cnt = '0;
    logic            branch_flush_en = 0;
    logic [WAYS-1:0] dispatch_grant;
    logic [CW-1:0]   dispatch_cnt;
    logic            fetch_stall, recovering, rob_full, rob_empty;
    logic [OW-1:0]   rob_count;
    logic [31:0]     stall_cycles;

    dispatch_ctrl #(.WAYS(WAYS), .ROB_SIZE(ROB), .FLUSH_STALL(FS)) dut (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .rs_avail(rs_avail),
        .freelist_avail(freelist_avail), .rob_retire_cnt(rob_retire_cnt),
        .branch_flush_en(branch_flush_en), .dispatch_grant(dispatch_grant),
        .dispatch_cnt(dispatch_cnt), .fetch_stall(fetch_stall), .recovering(recovering),
        .rob_count(rob_count), .rob_full(rob_full), .rob_empty(rob_empty),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [2:0]  grant;
        int          cnt;
        logic        stall;
        logic        rec;
        int          rob;
        logic        full;
        logic        empty;
        logic [31:0] sc;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          total = 0, bad = 0;
    int          m_rob = 0, m_left = 0;
    logic [31:0] m_sc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: blocked while flushing or while FS post-flush cycles remain.
    task automatic step(input logic [2:0] fv, input int rs, input int fl, input int ret,
                        input logic fe, input logic rst);
        int v, n;
        exp_t e;
        v = 0;
        for (int i = 0; i < WAYS; i++) if (fv[i] && v == i) v++;
        n = v;
        if (rs < n) n = rs;
        if (fl < n) n = fl;
        if (ROB - m_rob < n) n = ROB - m_rob;
        if (rst || fe || m_left > 0) n = 0;
        if (!fe && ret > m_rob + n) ret = m_rob + n;
        reset = rst; fetch_valid = fv; rs_avail = CW'(rs); freelist_avail = CW'(fl);
        rob_retire_cnt = CW'(ret); branch_flush_en = fe;
        e.rst = rst; e.grant = 3'((1 << n) - 1); e.cnt = n; e.stall = v > n;
        e.rec = m_left > 0; e.rob = m_rob; e.full = m_rob == ROB; e.empty = m_rob == 0; e.sc = m_sc;
        q.push_back(e);
        if (rst) begin
            m_rob = 0; m_left = 0; m_sc = 0;
        end else begin
            if (v > n) m_sc++;
            if (fe) begin
                m_rob = 0; m_left = FS;
            end else begin
                m_rob = m_rob + n - ret;
                if (m_left > 0) m_left--;
            end
        end
        @(posedge clock); #1;
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("grant", 32'(dispatch_grant), 32'(me.grant));
            chk("cnt", 32'(dispatch_cnt), 32'(me.cnt));
            if (!me.rst) chk("fetch_stall", 32'(fetch_stall), 32'(me.stall));
            chk("recovering", 32'(recovering), 32'(me.rec));
            chk("rob_count", 32'(rob_count), 32'(me.rob));
            chk("rob_full", 32'(rob_full), 32'(me.full));
            chk("rob_empty", 32'(rob_empty), 32'(me.empty));
            chk("stall_cycles", stall_cycles, me.sc);
        end
    end

    initial begin
        @(posedge clock); #1;
        step(3'b111, 3, 3, 0, 0, 1);
        repeat (11) step(3'b111, 3, 3, 0, 0, 0);
        step(3'b111, 3, 3, 2, 0, 0);
        step(3'b111, 3, 3, 0, 0, 0);
        step(3'b111, 3, 3, 0, 1, 0);
        repeat (2) step(3'b111, 3, 3, 0, 0, 0);
        step(3'b111, 3, 3, 0, 0, 0);
        step(3'b011, 3, 3, 0, 0, 0);
        step(3'b101, 3, 3, 0, 0, 0);
        step(3'b101, 0, 3, 0, 0, 0);
        step(3'b111, 3, 3, 0, 1, 0);
        step(3'b111, 3, 3, 0, 1, 0);
        repeat (4) step(3'b111, 3, 3, 0, 0, 0);
        step(3'b111, 3, 3, 0, 1, 0);
        step(3'b111, 3, 3, 0, 0, 0);
        step(3'b111, 3, 3, 0, 0, 1);
        repeat (2) step(3'b111, 3, 3, 0, 0, 0);
        for (int k = 0; k < 3000; k++)
            step(3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
        repeat (2) @(negedge clock);
        chk("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
